// File: rtl/ifetch_unit.sv
// Instruction fetch sequencer: reads imem at the current PC, queues {pc, inst} for decode,
// then hands the PC register its next value (sequential or redirect) and waits for pc_work.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | held in reset or os==0; nothing requested
// REQ   | imem read of pc_out outstanding (suppressed while queue full)
// ADV   | pc_wr asserted with next_pc, waiting for the PC's pc_work pulse
module ifetch_unit #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        os,
    input  logic [29:0] pc_out,
    input  logic        pc_work,
    output logic [29:0] next_pc,
    output logic        pc_wr,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_pc,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [29:0] inst_pc,
    input  logic        inst_ready
);

    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_ADV  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          redir_pend;
    logic [29:0]   redir_tgt;

    logic [31:0]   q_inst [QDEPTH];
    logic [29:0]   q_pc   [QDEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic          flush_all;
    logic          redir_take;
    logic          q_full;
    logic          push;
    logic          pop;
    logic          q_flush;

    assign flush_all  = reset | ~os;
    assign redir_take = redirect_valid & (state != S_IDLE);
    assign q_full     = (count == QFULL);
    // A same-cycle redirect discards the returning read.
    assign push       = (state == S_REQ) & ~q_full & imem_ack & ~redirect_valid;
    assign pop        = inst_valid & inst_ready;
    assign q_flush    = flush_all | redir_take;

    always_ff @(posedge clk) begin
        if (flush_all) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (redirect_valid) begin
                    state_nxt = S_ADV;
                end else if (!q_full && imem_ack) begin
                    state_nxt = S_ADV;
                end
            end
            S_ADV: begin
                // A redirect coinciding with pc_work means the PC took a stale value.
                if (redirect_valid) begin
                    state_nxt = S_ADV;
                end else if (pc_work) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc_out;
        pc_wr     = 1'b0;
        next_pc   = 30'd0;
        case (state)
            S_REQ: imem_req = ~q_full;
            S_ADV: begin
                pc_wr   = 1'b1;
                next_pc = redir_pend ? redir_tgt : (pc_out + 30'd1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (flush_all) begin
            redir_pend <= 1'b0;
            redir_tgt  <= 30'd0;
        end else if (redir_take) begin
            redir_pend <= 1'b1;
            redir_tgt  <= redirect_pc;
        end else if ((state == S_ADV) && pc_work) begin
            redir_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (q_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]   <= pc_out;
        end
    end

    assign inst_valid = (count != '0);
    assign inst       = q_inst[rd_ptr];
    assign inst_pc    = q_pc[rd_ptr];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: the PC register and imem are driven by hand; a scoreboard
// queue holds expected {pc, inst} pairs and a monitor checks them as decode pops entries.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        os;
    logic [29:0] pc_out;
    logic        pc_work;
    logic [29:0] next_pc;
    logic        pc_wr;
    logic        redirect_valid;
    logic [29:0] redirect_pc;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [29:0] inst_pc;
    logic        inst_ready;

    int total = 0;
    int bad   = 0;
    logic [61:0] exp_q [$];

    ifetch_unit #(.QDEPTH(2)) dut (
        .clk(clk), .reset(reset), .os(os),
        .pc_out(pc_out), .pc_work(pc_work), .next_pc(next_pc), .pc_wr(pc_wr),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // Each negedge with valid & ready is exactly one pop at the following rising edge.
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", {2'b00, inst_pc}, 32'hffffffff);
            end else begin
                chk("sb_inst_pc", {2'b00, inst_pc}, {2'b00, exp_q[0][61:32]});
                chk("sb_inst", inst, exp_q[0][31:0]);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1; os = 1'b1; pc_out = 30'hbff; pc_work = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; imem_ack = 1'b0; imem_rdata = '0;
        inst_ready = 1'b1;
        tick; tick;
        settle;
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc_wr", {31'd0, pc_wr}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_next_pc", {2'b00, next_pc}, 32'd0);
        reset = 1'b0;

        // 1: first fetch at 0xbff, ack on the first request cycle
        tick;
        settle;
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", {2'b00, imem_addr}, 32'hbff);
        imem_ack = 1'b1; imem_rdata = 32'hdead0001;
        exp_q.push_back({30'hbff, 32'hdead0001});
        tick;
        imem_ack = 1'b0;
        settle;
        chk("t1_inst_valid", {31'd0, inst_valid}, 32'd1);
        chk("t1_pc_wr", {31'd0, pc_wr}, 32'd1);
        chk("t1_next_pc", {2'b00, next_pc}, 32'hc00);
        chk("t1_req_drop", {31'd0, imem_req}, 32'd0);
        tick;
        pc_out = 30'hc00; pc_work = 1'b1;
        settle;
        chk("t1_pc_wr_hold", {31'd0, pc_wr}, 32'd1);
        tick;
        pc_work = 1'b0;
        settle;
        chk("t1_req_after_work", {31'd0, imem_req}, 32'd1);
        chk("t1_addr2", {2'b00, imem_addr}, 32'hc00);

        // 2: decode stalled, queue fills after two pushes
        inst_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'haaaa0002;
        exp_q.push_back({30'hc00, 32'haaaa0002});
        tick;
        imem_ack = 1'b0;
        tick;
        pc_out = 30'hc01; pc_work = 1'b1;
        tick;
        pc_work = 1'b0;
        settle;
        chk("t2_req_one", {31'd0, imem_req}, 32'd1);
        imem_ack = 1'b1; imem_rdata = 32'hbbbb0002;
        exp_q.push_back({30'hc01, 32'hbbbb0002});
        tick;
        imem_ack = 1'b0;
        tick;
        pc_out = 30'hc02; pc_work = 1'b1;
        tick;
        pc_work = 1'b0;
        settle;
        chk("t2_full_no_req", {31'd0, imem_req}, 32'd0);
        chk("t2_head_pc", {2'b00, inst_pc}, 32'hc00);
        tick;
        settle;
        chk("t2_full_hold", {31'd0, imem_req}, 32'd0);
        inst_ready = 1'b1;
        tick;
        inst_ready = 1'b0;
        settle;
        chk("t2_req_reassert", {31'd0, imem_req}, 32'd1);
        chk("t2_addr", {2'b00, imem_addr}, 32'hc02);

        // 3: redirect in REQ with a same-cycle ack flushes and drops the read
        redirect_valid = 1'b1; redirect_pc = 30'h100;
        imem_ack = 1'b1; imem_rdata = 32'h0badf00d;
        exp_q.delete();
        tick;
        redirect_valid = 1'b0; imem_ack = 1'b0;
        settle;
        chk("t3_queue_empty", {31'd0, inst_valid}, 32'd0);
        chk("t3_pc_wr", {31'd0, pc_wr}, 32'd1);
        chk("t3_next_pc", {2'b00, next_pc}, 32'h100);
        chk("t3_no_req", {31'd0, imem_req}, 32'd0);
        inst_ready = 1'b1;

        // 4: redirect coincides with pc_work
        tick;
        pc_out = 30'h100; pc_work = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 30'h200;
        tick;
        pc_work = 1'b0; redirect_valid = 1'b0;
        settle;
        chk("t4_pc_wr_held", {31'd0, pc_wr}, 32'd1);
        chk("t4_next_pc", {2'b00, next_pc}, 32'h200);
        chk("t4_no_req", {31'd0, imem_req}, 32'd0);
        tick;
        pc_out = 30'h200; pc_work = 1'b1;
        tick;
        pc_work = 1'b0;
        settle;
        chk("t4_req", {31'd0, imem_req}, 32'd1);
        chk("t4_addr", {2'b00, imem_addr}, 32'h200);

        // 5: os drop mid-fetch, then restart
        inst_ready = 1'b0;
        imem_ack = 1'b1; imem_rdata = 32'hc5c5c5c5;
        tick;
        imem_ack = 1'b0;
        os = 1'b0;
        settle;
        chk("t5_valid_before", {31'd0, inst_valid}, 32'd1);
        tick;
        settle;
        chk("t5_flush_valid", {31'd0, inst_valid}, 32'd0);
        chk("t5_flush_req", {31'd0, imem_req}, 32'd0);
        chk("t5_flush_pc_wr", {31'd0, pc_wr}, 32'd0);
        chk("t5_flush_next_pc", {2'b00, next_pc}, 32'd0);
        os = 1'b1; pc_out = 30'h300;
        tick;
        settle;
        chk("t5_restart_req", {31'd0, imem_req}, 32'd1);
        chk("t5_restart_addr", {2'b00, imem_addr}, 32'h300);
        chk("t5_restart_empty", {31'd0, inst_valid}, 32'd0);

        // 6: PC wrap and a slow pc_work
        inst_ready = 1'b1;
        pc_out = 30'h3fffffff;
        imem_ack = 1'b1; imem_rdata = 32'hd6d6d6d6;
        exp_q.push_back({30'h3fffffff, 32'hd6d6d6d6});
        tick;
        imem_ack = 1'b0;
        settle;
        chk("t6_next_pc_wrap", {2'b00, next_pc}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick;
            settle;
            chk("t6_pc_wr_wait", {31'd0, pc_wr}, 32'd1);
            chk("t6_next_pc_wait", {2'b00, next_pc}, 32'd0);
        end
        pc_out = 30'h0; pc_work = 1'b1;
        tick;
        pc_work = 1'b0;
        settle;
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr", {2'b00, imem_addr}, 32'd0);

        tick; tick;
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
